// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared definitions for the TM1638 display driver.
//   - TM1638 command bytes (data-command, address-command, display-control)
//   - seg7(): BCD digit to 7-segment pattern (bit0=a .. bit6=g, bit7=DP)
//   - state_t: frame sequencer states
package tm1638_pkg;

  localparam logic [7:0] CMD_DATA   = 8'h40;  // data write, auto-increment address
  localparam logic [7:0] CMD_ADDR   = 8'hC0;  // start address 0
  localparam logic [7:0] CMD_DISP   = 8'h88;  // display on, brightness in bits [2:0]
  localparam logic [7:0] SEG_DP     = 8'h80;  // decimal point, used as the colon
  localparam logic [7:0] SEG_DASH   = 8'h40;  // shown for non-BCD inputs
  localparam int unsigned DATA_BYTES = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD1,
    S_GAP1,
    S_ADDR,
    S_GAP2,
    S_CMD3
  } state_t;

  function automatic logic [7:0] seg7(input logic [3:0] bcd);
    logic [7:0] pat;
    case (bcd)
      4'd0:    pat = 8'h3F;
      4'd1:    pat = 8'h06;
      4'd2:    pat = 8'h5B;
      4'd3:    pat = 8'h4F;
      4'd4:    pat = 8'h66;
      4'd5:    pat = 8'h6D;
      4'd6:    pat = 8'h7D;
      4'd7:    pat = 8'h07;
      4'd8:    pat = 8'h7F;
      4'd9:    pat = 8'h6F;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/tm1638_if.sv
// tm1638_if: TM1638 3-wire bus.
//   tm_stb  active-low frame strobe
//   tm_clk  serial clock, device samples tm_dio on its rising edge
//   tm_dio  serial data, LSB first
// master: driver side, slave: display board / monitor side.
interface tm1638_if;
  logic tm_stb;
  logic tm_clk;
  logic tm_dio;

  modport master (output tm_stb, output tm_clk, output tm_dio);
  modport slave  (input  tm_stb, input  tm_clk, input  tm_dio);
endinterface

// File: rtl/tm1638_byte_tx.sv
// tm1638_byte_tx: serialises one byte LSB first, one half-bit per tick.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   tick       bus-rate strobe; sclk/sdio change only on tick cycles
//   load       capture data; transmission starts on the next tick
//   data       byte to send
//   done       combinational: high on the tick that makes the last sclk rise;
//              a load in that same cycle chains the next byte with no gap
//   sclk,sdio  registered serial clock/data; both idle high
import tm1638_pkg::*;

module tm1638_byte_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] data,
  output logic       done,
  output logic       sclk,
  output logic       sdio
);

  logic [7:0] shreg;
  logic [3:0] phase;   // even: sclk falls + next bit out, odd: sclk rises
  logic       active;

  assign done = tick && active && (phase == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      phase  <= '0;
      active <= 1'b0;
      sclk   <= 1'b1;
      sdio   <= 1'b1;
    end else begin
      if (tick) begin
        if (active) begin
          if (!phase[0]) begin
            sclk <= 1'b0;
            sdio <= shreg[0];
          end else begin
            sclk  <= 1'b1;
            shreg <= shreg >> 1;
          end
          phase <= phase + 1'b1;
          if (phase == 4'd15) active <= 1'b0;
        end else begin
          sclk <= 1'b1;
          sdio <= 1'b1;
        end
      end
      // Placed last so a chained load on the final rise tick wins over the
      // shift and the return to idle.
      if (load) begin
        shreg  <= data;
        phase  <= '0;
        active <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tm1638_driver.sv
// tm1638_driver: refreshes a TM1638 board with six BCD clock digits.
// Each frame snapshots led1..led6, then sends three STB bursts:
//   0x40 | 0xC0 + 16 data bytes | 0x88|BRIGHT, separated by 2-tick STB-high
//   gaps, then idles REFRESH_TICKS ticks before the next frame.
// Ports:
//   clki        system clock
//   rs          synchronous active-high reset (aborts a frame immediately)
//   led1..led6  BCD digits: sec units/tens, min units/tens, hour units/tens
//   bus         TM1638 STB/CLK/DIO (master modport)
//   busy        high from the CMD1 STB fall until frame_done
//   frame_done  1-cycle pulse as STB rises after the display-control byte
import tm1638_pkg::*;

module tm1638_driver #(
  parameter int unsigned CLK_DIV       = 50,
  parameter int unsigned REFRESH_TICKS = 1000,
  parameter logic [2:0]  BRIGHT        = 3'd7
) (
  input  logic           clki,
  input  logic           rs,
  input  logic [3:0]     led1,
  input  logic [3:0]     led2,
  input  logic [3:0]     led3,
  input  logic [3:0]     led4,
  input  logic [3:0]     led5,
  input  logic [3:0]     led6,
  tm1638_if.master       bus,
  output logic           busy,
  output logic           frame_done
);

  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam int unsigned IW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  // Loaded at frame_done so the next STB fall lands REFRESH_TICKS ticks later.
  localparam logic [IW-1:0] IDLE_LOAD = (REFRESH_TICKS > 0) ? IW'(REFRESH_TICKS - 1) : '0;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  state_t        state;
  logic          stb;
  logic [IW-1:0] idle_cnt;
  logic          gap_cnt;
  logic          lead;      // first tick of a burst: STB already low, load first byte
  logic          trail;     // last byte finished: raise STB on the next tick
  logic [4:0]    byte_idx;  // data bytes handed to the shifter in the ADDR burst
  logic [3:0]    snap [6];  // snap[0] = led1 .. snap[5] = led6

  logic [7:0]    data_byte;
  logic [7:0]    tx_data;
  logic          tx_load;
  logic          tx_done;
  logic          sclk;
  logic          sdio;

  always_ff @(posedge clki) begin
    if (rs) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Even address 2k carries grid k+1; grid1..grid6 show led6..led1, so grid
  // g (0-based) reads snap[5-g]. Grids 2 and 4 carry the colon.
  always_comb begin
    data_byte = '0;
    if (!byte_idx[0] && (byte_idx[3:1] < 3'd6)) begin
      data_byte = seg7(snap[3'd5 - byte_idx[3:1]]);
      if (byte_idx[3:1] == 3'd1 || byte_idx[3:1] == 3'd3) data_byte = data_byte | SEG_DP;
    end
  end

  always_comb begin
    tx_load = 1'b0;
    tx_data = data_byte;
    if (tick && (state == S_CMD1 || state == S_ADDR || state == S_CMD3)) begin
      if (lead) begin
        tx_load = 1'b1;
        case (state)
          S_CMD1:  tx_data = CMD_DATA;
          S_ADDR:  tx_data = CMD_ADDR;
          default: tx_data = CMD_DISP | {5'b0, BRIGHT};
        endcase
      end else if (tx_done && state == S_ADDR && byte_idx < 5'(DATA_BYTES)) begin
        tx_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clki) begin
    if (rs) begin
      state      <= S_IDLE;
      stb        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      idle_cnt   <= '0;
      gap_cnt    <= 1'b0;
      lead       <= 1'b0;
      trail      <= 1'b0;
      byte_idx   <= '0;
      snap       <= '{default: '0};
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (idle_cnt == '0) begin
              snap  <= '{led1, led2, led3, led4, led5, led6};
              stb   <= 1'b0;
              busy  <= 1'b1;
              lead  <= 1'b1;
              state <= S_CMD1;
            end else begin
              idle_cnt <= idle_cnt - 1'b1;
            end
          end
          S_GAP1, S_GAP2: begin
            if (!gap_cnt) begin
              gap_cnt <= 1'b1;
            end else begin
              gap_cnt <= 1'b0;
              stb     <= 1'b0;
              lead    <= 1'b1;
              state   <= (state == S_GAP1) ? S_ADDR : S_CMD3;
            end
          end
          default: begin
            if (lead) begin
              lead     <= 1'b0;
              byte_idx <= '0;
            end else if (trail) begin
              trail <= 1'b0;
              stb   <= 1'b1;
              case (state)
                S_CMD1: state <= S_GAP1;
                S_ADDR: state <= S_GAP2;
                default: begin
                  state      <= S_IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  idle_cnt   <= IDLE_LOAD;
                end
              endcase
            end else if (tx_done) begin
              if (tx_load) byte_idx <= byte_idx + 1'b1;
              else         trail    <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  tm1638_byte_tx u_byte_tx (
    .clk  (clki),
    .rst  (rs),
    .tick (tick),
    .load (tx_load),
    .data (tx_data),
    .done (tx_done),
    .sclk (sclk),
    .sdio (sdio)
  );

  assign bus.tm_stb = stb;
  assign bus.tm_clk = sclk;
  assign bus.tm_dio = sdio;

endmodule

// File: tb/tb_tm1638_driver.sv
// Bench for tm1638_driver: three instances (BRIGHT 7/3/0) share clock, reset
// and digits; a bus decoder rebuilds the transmitted bytes and a reference
// model derives expected frames from the digit-to-grid rules.
module tb_tm1638_driver;

  localparam int unsigned CDIV  = 2;
  localparam int unsigned REFR  = 4;
  localparam int          BOUND = 3000;

  logic       clki = 1'b0;
  logic       rs   = 1'b1;
  logic [3:0] led [1:6];
  logic       busy0, busy1, busy2, fd0, fd1, fd2;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic mon_en = 1'b0;

  logic [7:0] got_q[$];
  int         burst_q[$];
  logic [7:0] exp_q[$];

  tm1638_if bus0();
  tm1638_if bus1();
  tm1638_if bus2();

  always #5 clki = ~clki;
  always @(posedge clki) cyc <= cyc + 1;

  tm1638_driver #(.CLK_DIV(CDIV), .REFRESH_TICKS(REFR), .BRIGHT(3'd7)) dut (
    .clki(clki), .rs(rs), .led1(led[1]), .led2(led[2]), .led3(led[3]),
    .led4(led[4]), .led5(led[5]), .led6(led[6]), .bus(bus0),
    .busy(busy0), .frame_done(fd0));

  tm1638_driver #(.CLK_DIV(CDIV), .REFRESH_TICKS(REFR), .BRIGHT(3'd3)) dut_b3 (
    .clki(clki), .rs(rs), .led1(led[1]), .led2(led[2]), .led3(led[3]),
    .led4(led[4]), .led5(led[5]), .led6(led[6]), .bus(bus1),
    .busy(busy1), .frame_done(fd1));

  tm1638_driver #(.CLK_DIV(CDIV), .REFRESH_TICKS(REFR), .BRIGHT(3'd0)) dut_b0 (
    .clki(clki), .rs(rs), .led1(led[1]), .led2(led[2]), .led3(led[3]),
    .led4(led[4]), .led5(led[5]), .led6(led[6]), .bus(bus2),
    .busy(busy2), .frame_done(fd2));

  logic [2:0] stb_v, clk_v, dio_v;
  assign stb_v = {bus2.tm_stb, bus1.tm_stb, bus0.tm_stb};
  assign clk_v = {bus2.tm_clk, bus1.tm_clk, bus0.tm_clk};
  assign dio_v = {bus2.tm_dio, bus1.tm_dio, bus0.tm_dio};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Bus decoder and timing monitor, sampled on the falling clock edge.
  logic [2:0] p_stb = '1, p_clk = '1, p_dio = '1;
  logic [7:0] shf [3];
  int         nb [3];
  int         inb [3];
  logic [7:0] last_b [3];
  int         hi_cnt = 0;
  logic       p_busy = 1'b0;

  always @(negedge clki) begin
    for (int k = 0; k < 3; k++) begin
      if (p_stb[k] && !stb_v[k]) begin
        nb[k]  = 0;
        inb[k] = 0;
      end
      if (!stb_v[k] && !p_clk[k] && clk_v[k]) begin
        shf[k] = {dio_v[k], shf[k][7:1]};
        nb[k]++;
        if (nb[k] == 8) begin
          nb[k] = 0;
          inb[k]++;
          last_b[k] = shf[k];
          if (k == 0) got_q.push_back(shf[k]);
        end
      end
      if (k == 0 && !p_stb[0] && stb_v[0]) burst_q.push_back(inb[0]);
    end
    if (mon_en) begin
      if (!p_clk[0] && clk_v[0]) chk("dio_stable_at_clk_rise", 32'(dio_v[0]), 32'(p_dio[0]));
      if (p_stb[0] != stb_v[0]) chk("clk_high_at_stb_edge", {p_clk[0], clk_v[0]}, 32'h3);
      if (stb_v[0]) chk("lines_high_while_stb_high", {clk_v[0], dio_v[0]}, 32'h3);
      if (p_stb[0] && !stb_v[0] && p_busy) chk("stb_gap_min", 32'(hi_cnt >= 2 * CDIV), 32'h1);
    end
    hi_cnt = stb_v[0] ? hi_cnt + 1 : 0;
    p_stb  = stb_v;
    p_clk  = clk_v;
    p_dio  = dio_v;
    p_busy = busy0;
  end

  task automatic step();
    @(negedge clki);
    #1;
  endtask

  task automatic clear_cap();
    got_q.delete();
    burst_q.delete();
  endtask

  task automatic rand_leds();
    for (int i = 1; i <= 6; i++) led[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_fall(input string tag, output int t);
    logic p;
    int   n;
    p = bus0.tm_stb;
    for (n = 0; n < BOUND; n++) begin
      step();
      if (p && !bus0.tm_stb) break;
      p = bus0.tm_stb;
    end
    chk({tag, "_timeout"}, 32'(n < BOUND), 32'h1);
    t = cyc;
  endtask

  task automatic wait_fd(input string tag, output int t);
    int n;
    for (n = 0; n < BOUND; n++) begin
      step();
      if (fd0) break;
    end
    chk({tag, "_timeout"}, 32'(n < BOUND), 32'h1);
    t = cyc;
  endtask

  // Reference frame: 0x40, 0xC0, 16 data bytes (even address = grid, odd = 0),
  // then 0x88|brightness. Grid g (1..6) shows led(7-g); grids 2 and 4 get the colon.
  task automatic build_exp(input logic [3:0] d [1:6], input logic [2:0] br);
    logic [7:0] lut [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    logic [7:0] grid [1:8];
    logic [3:0] v;
    exp_q.delete();
    exp_q.push_back(8'h40);
    exp_q.push_back(8'hC0);
    for (int g = 1; g <= 8; g++) begin
      grid[g] = 8'h00;
      if (g <= 6) begin
        v = d[7 - g];
        grid[g] = (v > 4'd9) ? 8'h40 : lut[v];
        if (g == 2 || g == 4) grid[g] = grid[g] | 8'h80;
      end
    end
    for (int a = 0; a < 16; a++) exp_q.push_back((a % 2 == 1) ? 8'h00 : grid[a / 2 + 1]);
    exp_q.push_back(8'h88 | {5'b0, br});
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    chk({tag, "_bursts"}, 32'(burst_q.size() == 3 && burst_q[0] == 1 &&
                              burst_q[1] == 17 && burst_q[2] == 1), 32'h1);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  logic [3:0] snap [1:6];
  int t0, t1, t2, n;

  initial begin
    led[1] = 4'd6; led[2] = 4'd5; led[3] = 4'd4;
    led[4] = 4'd3; led[5] = 4'd2; led[6] = 4'd1;
    rs = 1'b1;
    repeat (3) step();
    chk("rst_stb",  32'(bus0.tm_stb), 32'h1);
    chk("rst_clk",  32'(bus0.tm_clk), 32'h1);
    chk("rst_dio",  32'(bus0.tm_dio), 32'h1);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_fd",   32'(fd0), 32'h0);

    // Frame 1: fixed digits 12:34:56 (led6..led1 = 1..6)
    rs = 1'b0;
    clear_cap();
    mon_en = 1'b1;
    snap = led;
    wait_fall("f1_start", t0);
    chk("f1_busy_rise", 32'(busy0), 32'h1);
    wait_fd("f1_done", t1);
    chk("f1_duration", 32'(t1 - t0), 32'd628);
    chk("f1_busy_fall", 32'(busy0), 32'h0);
    chk("f1_stb_at_done", 32'(bus0.tm_stb), 32'h1);
    build_exp(snap, 3'd7);
    check_frame("f1");
    chk("f1_grid2_literal", 32'(got_q[4]), 32'hDB);
    chk("f1_disp_literal", 32'(got_q[18]), 32'h8F);
    chk("bright3_disp", 32'(last_b[1]), 32'h8B);
    chk("bright0_disp", 32'(last_b[2]), 32'h88);

    // Frame 2: inputs churn mid-frame; frame carries the start-of-frame values
    clear_cap();
    rand_leds();
    snap = led;
    wait_fall("f2_start", t2);
    chk("refresh_gap", 32'(t2 - t1), 32'(REFR * CDIV));
    n = 0;
    while (!fd0 && n < BOUND) begin
      step();
      n++;
      if (n % 10 == 0) rand_leds();
    end
    chk("f2_done_timeout", 32'(n < BOUND), 32'h1);
    build_exp(snap, 3'd7);
    check_frame("f2_no_tear");

    // Frame 3: carries the last values presented during frame 2
    snap = led;
    clear_cap();
    wait_fd("f3_done", t1);
    build_exp(snap, 3'd7);
    check_frame("f3_new_values");

    // Non-BCD inputs on led3 show a dash plus colon on grid4
    for (int i = 0; i < 6; i++) begin
      rand_leds();
      led[3] = 4'hA + 4'(i);
      snap = led;
      clear_cap();
      wait_fd($sformatf("dash%0d_done", i), t1);
      build_exp(snap, 3'd7);
      check_frame($sformatf("dash%0d", i));
      chk($sformatf("dash%0d_grid4", i), 32'(got_q[8]), 32'hC0);
    end

    // Reset pulse in the middle of the data burst
    wait_fall("abort_start", t0);
    for (int i = 0; i < 100; i++) step();
    mon_en = 1'b0;
    rs = 1'b1;
    step();
    chk("abort_stb",  32'(bus0.tm_stb), 32'h1);
    chk("abort_clk",  32'(bus0.tm_clk), 32'h1);
    chk("abort_dio",  32'(bus0.tm_dio), 32'h1);
    chk("abort_busy", 32'(busy0), 32'h0);
    rs = 1'b0;
    clear_cap();
    mon_en = 1'b1;
    snap = led;
    wait_fd("post_abort_done", t1);
    build_exp(snap, 3'd7);
    check_frame("post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
